cordic_fsm_param: RTL and testbench

//  Parametrised CORDIC sequencer: next generation of the sine/cosine CORDIC control FSM.

---
 rtl/cordic_fsm_param_if.sv | 51 +++++
 rtl/cordic_fsm_param.sv | 225 ++++++++++++++++++++++
 tb/tb_cordic_fsm_param.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_fsm_param_if.sv
// Control bundle between the CORDIC sequencer (master) and its datapath / consumer (slave).
// ITER_W must match the sequencer's iteration counter width.
interface cordic_fsm_param_if #(
  parameter int ITER_W = 4
);
  // consumer / datapath -> sequencer
  logic              beg_fsm_cordic;
  logic              ack_fsm_cordic;
  logic              operation;
  logic              mode_in;
  logic [1:0]        shift_region_flag;
  logic              ready_add_subt;

  // sequencer -> consumer / datapath
  logic              reset_reg_cordic;
  logic              ready_cordic;
  logic              error_cordic;
  logic              busy;
  logic              beg_add_subt;
  logic              ack_add_subt;
  logic              mode;
  logic              sel_mux_1;
  logic [1:0]        sel_mux_2;
  logic [1:0]        sel_mux_3;
  logic [ITER_W-1:0] iter_count;
  logic              enab_rb1;
  logic              enab_rb2;
  logic              enab_d_ff_xn;
  logic              enab_d_ff_yn;
  logic              enab_d_ff_zn;
  logic              enab_dff_shifted;
  logic              enab_dff_lut;
  logic              enab_dff_sign;
  logic              enab_d_ff_out;

  modport master (
    input  beg_fsm_cordic, ack_fsm_cordic, operation, mode_in, shift_region_flag, ready_add_subt,
    output reset_reg_cordic, ready_cordic, error_cordic, busy, beg_add_subt, ack_add_subt, mode,
           sel_mux_1, sel_mux_2, sel_mux_3, iter_count, enab_rb1, enab_rb2,
           enab_d_ff_xn, enab_d_ff_yn, enab_d_ff_zn,
           enab_dff_shifted, enab_dff_lut, enab_dff_sign, enab_d_ff_out
  );

  modport slave (
    output beg_fsm_cordic, ack_fsm_cordic, operation, mode_in, shift_region_flag, ready_add_subt,
    input  reset_reg_cordic, ready_cordic, error_cordic, busy, beg_add_subt, ack_add_subt, mode,
           sel_mux_1, sel_mux_2, sel_mux_3, iter_count, enab_rb1, enab_rb2,
           enab_d_ff_xn, enab_d_ff_yn, enab_d_ff_zn,
           enab_dff_shifted, enab_dff_lut, enab_dff_sign, enab_d_ff_out
  );
endinterface

// File: rtl/cordic_fsm_param.sv
// Parametrised CORDIC control sequencer: rotation/vectoring modes, internal iteration and
// variable counters, rotation correction pass, and an add/subt-unit timeout with error exit.
module cordic_fsm_param #(
  parameter int N_ITER      = 16,
  parameter int ITER_W      = 4,
  parameter int ADD_TIMEOUT = 64,
  parameter int TMR_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  cordic_fsm_param_if.master    bus
);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_LOAD, S_SEL, S_RB2, S_SHIFT, S_VSEL,
    S_BEG, S_WAIT, S_ACK, S_OUTSEL, S_OUT, S_DONE, S_ERR
  } state_t;

  localparam logic [ITER_W-1:0] ITER_LAST  = ITER_W'(N_ITER - 1);
  localparam bit                TMO_EN     = (ADD_TIMEOUT > 0);
  localparam int                TMR_LAST_I = (ADD_TIMEOUT > 0) ? ADD_TIMEOUT - 1 : 0;
  localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(TMR_LAST_I);

  localparam logic [1:0] VAR_X = 2'd0;
  localparam logic [1:0] VAR_Y = 2'd1;
  localparam logic [1:0] VAR_Z = 2'd2;

  state_t            state_q, state_d;
  logic [ITER_W-1:0] iter_q,  iter_d;
  logic [1:0]        var_q,   var_d;
  logic [TMR_W-1:0]  tmr_q,   tmr_d;
  logic              corr_q,  corr_d;
  logic              op_q,    op_d;
  logic              mode_q,  mode_d;
  logic [1:0]        flag_q,  flag_d;

  // Correction target: 0 -> X, 1 -> Y, from the latched operation and quadrant.
  logic       corr_tgt;
  logic [1:0] cur_var;
  logic [1:0] out_sel;

  assign corr_tgt = op_q ^ flag_q[1] ^ flag_q[0];
  assign cur_var  = corr_q ? {1'b0, corr_tgt} : var_q;
  assign out_sel  = mode_q ? (op_q ? VAR_Z : VAR_X) : {1'b0, corr_tgt};

  // NOTE: state flops use non-blocking assignments only; the async reset clears every flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      iter_q  <= '0;
      var_q   <= '0;
      tmr_q   <= '0;
      corr_q  <= 1'b0;
      op_q    <= 1'b0;
      mode_q  <= 1'b0;
      flag_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      var_q   <= var_d;
      tmr_q   <= tmr_d;
      corr_q  <= corr_d;
      op_q    <= op_d;
      mode_q  <= mode_d;
      flag_q  <= flag_d;
    end
  end

  // NOTE: every _d and every output gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    var_d   = var_q;
    tmr_d   = tmr_q;
    corr_d  = corr_q;
    op_d    = op_q;
    mode_d  = mode_q;
    flag_d  = flag_q;

    bus.reset_reg_cordic = 1'b0;
    bus.ready_cordic     = 1'b0;
    bus.error_cordic     = 1'b0;
    bus.beg_add_subt     = 1'b0;
    bus.ack_add_subt     = 1'b0;
    bus.sel_mux_1        = 1'b0;
    bus.sel_mux_2        = VAR_X;
    bus.sel_mux_3        = VAR_X;
    bus.enab_rb1         = 1'b0;
    bus.enab_rb2         = 1'b0;
    bus.enab_d_ff_xn     = 1'b0;
    bus.enab_d_ff_yn     = 1'b0;
    bus.enab_d_ff_zn     = 1'b0;
    bus.enab_dff_shifted = 1'b0;
    bus.enab_dff_lut     = 1'b0;
    bus.enab_dff_sign    = 1'b0;
    bus.enab_d_ff_out    = 1'b0;

    unique case (state_q)
      S_INIT: begin
        bus.reset_reg_cordic = 1'b1;
        iter_d  = '0;
        var_d   = '0;
        tmr_d   = '0;
        corr_d  = 1'b0;
        state_d = S_IDLE;
      end

      S_IDLE: begin
        if (bus.beg_fsm_cordic) begin
          bus.enab_rb1 = 1'b1;
          op_d    = bus.operation;
          mode_d  = bus.mode_in;
          flag_d  = bus.shift_region_flag;
          iter_d  = '0;
          corr_d  = 1'b0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        bus.enab_rb1 = 1'b1;
        state_d      = S_SEL;
      end

      // The iteration mux stays selected while the post-mux register loads.
      S_SEL: begin
        bus.sel_mux_1 = (iter_q != '0);
        state_d       = S_RB2;
      end

      S_RB2: begin
        bus.sel_mux_1 = (iter_q != '0);
        bus.enab_rb2  = 1'b1;
        state_d       = S_SHIFT;
      end

      S_SHIFT: begin
        bus.enab_dff_shifted = 1'b1;
        bus.enab_dff_lut     = 1'b1;
        bus.enab_dff_sign    = 1'b1;
        var_d                = VAR_X;
        state_d              = S_VSEL;
      end

      // Operand select is held from VSEL until the add result is acknowledged.
      S_VSEL: begin
        bus.sel_mux_2 = cur_var;
        state_d       = S_BEG;
      end

      S_BEG: begin
        bus.sel_mux_2    = cur_var;
        bus.beg_add_subt = 1'b1;
        tmr_d            = '0;
        state_d          = S_WAIT;
      end

      S_WAIT: begin
        bus.sel_mux_2 = cur_var;
        if (bus.ready_add_subt) begin
          case (cur_var)
            VAR_X:   bus.enab_d_ff_xn = 1'b1;
            VAR_Y:   bus.enab_d_ff_yn = 1'b1;
            VAR_Z:   bus.enab_d_ff_zn = 1'b1;
            default: ;
          endcase
          state_d = S_ACK;
        end else if (TMO_EN && (tmr_q == TMR_LAST)) begin
          state_d = S_ERR;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_ACK: begin
        bus.sel_mux_2    = cur_var;
        bus.ack_add_subt = 1'b1;
        if (corr_q) begin
          state_d = S_OUTSEL;
        end else if (var_q != VAR_Z) begin
          var_d   = var_q + 2'd1;
          state_d = S_VSEL;
        end else if (iter_q != ITER_LAST) begin
          iter_d  = iter_q + ITER_W'(1);
          state_d = S_SEL;
        end else if (!mode_q) begin
          corr_d  = 1'b1;
          state_d = S_VSEL;
        end else begin
          state_d = S_OUTSEL;
        end
      end

      S_OUTSEL: begin
        bus.sel_mux_3 = out_sel;
        state_d       = S_OUT;
      end

      S_OUT: begin
        bus.sel_mux_3     = out_sel;
        bus.enab_d_ff_out = 1'b1;
        state_d           = S_DONE;
      end

      S_DONE: begin
        bus.sel_mux_3    = out_sel;
        bus.ready_cordic = 1'b1;
        if (bus.ack_fsm_cordic) state_d = S_INIT;
      end

      S_ERR: begin
        bus.error_cordic = 1'b1;
        if (bus.ack_fsm_cordic) state_d = S_INIT;
      end

      default: state_d = S_INIT;
    endcase
  end

  assign bus.busy = !((state_q == S_INIT) || (state_q == S_IDLE) ||
                      (state_q == S_DONE) || (state_q == S_ERR));
  assign bus.mode       = mode_q;
  assign bus.iter_count = iter_q;

endmodule

// File: tb/tb_cordic_fsm_param.sv
// Directed bench for cordic_fsm_param: vector table of full operations plus hand-written
// reset, timeout, abort and busy-start sequences.
module tb_cordic_fsm_param;

  localparam int N_ITER      = 4;
  localparam int ITER_W      = 4;
  localparam int ADD_TIMEOUT = 8;
  localparam int TMR_W       = 8;
  localparam int BUDGET      = 1000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cordic_fsm_param_if #(.ITER_W(ITER_W)) bus ();

  cordic_fsm_param #(
    .N_ITER(N_ITER), .ITER_W(ITER_W), .ADD_TIMEOUT(ADD_TIMEOUT), .TMR_W(TMR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       op;
    logic       md;
    logic [1:0] flag;
    int         delay;   // WAIT cycle (1-based) on which the add unit answers
    int         lat;     // cycles from the beg-sampling edge to ready_cordic
    int         begs;
    logic [1:0] sel3;
    logic [1:0] lsel2;   // operand select of the final add
    logic [2:0] len;     // {zn,yn,xn} enable of the final add
  } vec_t;

  vec_t vecs [9];

  int checks = 0;
  int passes = 0;
  int resp_delay = 1;
  int beg_cnt = 0, ack_cnt = 0, rb2_cnt = 0, out_cnt = 0;
  logic [1:0] prev_sel2 = 2'd0, last_sel2 = 2'd0;
  logic [2:0] last_en = 3'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] other_outs();
    return 32'({bus.ready_cordic, bus.error_cordic, bus.busy, bus.beg_add_subt, bus.ack_add_subt,
                bus.mode, bus.sel_mux_1, bus.sel_mux_2, bus.sel_mux_3, bus.iter_count,
                bus.enab_rb1, bus.enab_rb2, bus.enab_d_ff_xn, bus.enab_d_ff_yn, bus.enab_d_ff_zn,
                bus.enab_dff_shifted, bus.enab_dff_lut, bus.enab_dff_sign, bus.enab_d_ff_out});
  endfunction

  // Event monitor, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.beg_add_subt) begin
        beg_cnt++;
        last_sel2 = prev_sel2;
      end
      if (bus.ack_add_subt) ack_cnt++;
      if (bus.enab_rb2) rb2_cnt++;
      if (bus.enab_d_ff_out) out_cnt++;
      if (bus.enab_d_ff_xn || bus.enab_d_ff_yn || bus.enab_d_ff_zn)
        last_en = {bus.enab_d_ff_zn, bus.enab_d_ff_yn, bus.enab_d_ff_xn};
      prev_sel2 = bus.sel_mux_2;
    end
  end

  // Add/subt unit model: answers on WAIT cycle resp_delay after each start (0 = never).
  initial begin
    bus.ready_add_subt = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.beg_add_subt && resp_delay != 0) begin
        @(posedge clk); #1;
        for (int i = 1; i < resp_delay; i++) begin
          @(posedge clk); #1;
        end
        bus.ready_add_subt = 1'b1;
        @(posedge clk); #1;
        bus.ready_add_subt = 1'b0;
      end
    end
  end

  // Runs one operation from IDLE. ack_early holds ack_fsm_cordic high throughout;
  // poke raises beg_fsm_cordic for a while mid-operation.
  task automatic run_op(input vec_t v, input bit ack_early, input bit poke, input string tag);
    int b0, a0, r0, o0, k;
    resp_delay = v.delay;
    @(negedge clk);
    b0 = beg_cnt; a0 = ack_cnt; r0 = rb2_cnt; o0 = out_cnt;
    bus.operation         = v.op;
    bus.mode_in           = v.md;
    bus.shift_region_flag = v.flag;
    bus.beg_fsm_cordic    = 1'b1;
    bus.ack_fsm_cordic    = ack_early;
    @(negedge clk);
    bus.beg_fsm_cordic    = 1'b0;
    bus.operation         = ~v.op;
    bus.mode_in           = ~v.md;
    bus.shift_region_flag = ~v.flag;
    k = 0;
    while (!(bus.ready_cordic || bus.error_cordic) && k < BUDGET) begin
      @(negedge clk);
      k++;
      if (poke && k == 10) bus.beg_fsm_cordic = 1'b1;
      if (poke && k == 15) bus.beg_fsm_cordic = 1'b0;
    end
    check({tag, " latency"}, k, v.lat);
    check({tag, " ready"}, bus.ready_cordic, 1);
    check({tag, " error"}, bus.error_cordic, 0);
    check({tag, " busy"}, bus.busy, 0);
    check({tag, " beg_add_subt count"}, beg_cnt - b0, v.begs);
    check({tag, " ack_add_subt count"}, ack_cnt - a0, v.begs);
    check({tag, " enab_rb2 count"}, rb2_cnt - r0, N_ITER);
    check({tag, " enab_d_ff_out count"}, out_cnt - o0, 1);
    check({tag, " sel_mux_3"}, bus.sel_mux_3, v.sel3);
    check({tag, " last sel_mux_2"}, last_sel2, v.lsel2);
    check({tag, " last result enable"}, last_en, v.len);
    check({tag, " mode"}, bus.mode, v.md);
    check({tag, " iter_count"}, bus.iter_count, N_ITER - 1);
    if (!ack_early) begin
      @(negedge clk);
      check({tag, " ready held"}, bus.ready_cordic, 1);
      bus.ack_fsm_cordic = 1'b1;
    end
    @(negedge clk);
    bus.ack_fsm_cordic = 1'b0;
    check({tag, " INIT after ack"}, bus.reset_reg_cordic, 1);
    check({tag, " ready dropped"}, bus.ready_cordic, 0);
  endtask

  initial begin
    int k;
    //           op    md    flag  dly lat  begs sel3  lsel2 len
    vecs[0] = '{1'b0, 1'b0, 2'b00, 1,  67, 13, 2'd0, 2'd0, 3'b001};
    vecs[1] = '{1'b1, 1'b0, 2'b01, 1,  67, 13, 2'd0, 2'd0, 3'b001};
    vecs[2] = '{1'b1, 1'b0, 2'b00, 1,  67, 13, 2'd1, 2'd1, 3'b010};
    vecs[3] = '{1'b0, 1'b0, 2'b10, 1,  67, 13, 2'd1, 2'd1, 3'b010};
    vecs[4] = '{1'b1, 1'b1, 2'b00, 1,  63, 12, 2'd2, 2'd2, 3'b100};
    vecs[5] = '{1'b0, 1'b1, 2'b11, 1,  63, 12, 2'd0, 2'd2, 3'b100};
    vecs[6] = '{1'b0, 1'b0, 2'b00, 2,  80, 13, 2'd0, 2'd0, 3'b001};
    vecs[7] = '{1'b1, 1'b0, 2'b00, 8, 158, 13, 2'd1, 2'd1, 3'b010};
    vecs[8] = '{1'b1, 1'b1, 2'b10, 3,  87, 12, 2'd2, 2'd2, 3'b100};

    bus.beg_fsm_cordic    = 1'b0;
    bus.ack_fsm_cordic    = 1'b0;
    bus.operation         = 1'b0;
    bus.mode_in           = 1'b0;
    bus.shift_region_flag = 2'b00;
    reset = 1'b1;

    // Reset state and first cycle after release.
    #12;
    check("reset reset_reg_cordic", bus.reset_reg_cordic, 1);
    check("reset other outputs", other_outs(), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post-release INIT", bus.reset_reg_cordic, 1);
    @(negedge clk);
    check("post-release IDLE reset_reg", bus.reset_reg_cordic, 0);
    check("post-release IDLE outputs", other_outs(), 0);

    for (int i = 0; i < 9; i++) run_op(vecs[i], 1'b0, 1'b0, $sformatf("vec%0d", i));

    // ack already high on DONE entry, and a beg pulse while busy.
    run_op(vecs[0], 1'b1, 1'b0, "ack_early");
    run_op(vecs[2], 1'b0, 1'b1, "beg_while_busy");

    // Add unit never answers: error after ADD_TIMEOUT WAIT cycles, held until ack.
    resp_delay = 0;
    @(negedge clk);
    bus.operation = 1'b0; bus.mode_in = 1'b0; bus.shift_region_flag = 2'b00;
    bus.beg_fsm_cordic = 1'b1;
    @(negedge clk);
    bus.beg_fsm_cordic = 1'b0;
    k = 0;
    while (!bus.beg_add_subt && k < 20) begin @(negedge clk); k++; end
    check("timeout first beg seen", bus.beg_add_subt, 1);
    k = 0;
    while (!bus.error_cordic && k < 50) begin @(negedge clk); k++; end
    check("timeout wait cycles", k - 1, ADD_TIMEOUT);
    check("timeout ready", bus.ready_cordic, 0);
    check("timeout busy", bus.busy, 0);
    repeat (4) @(negedge clk);
    check("timeout error held", bus.error_cordic, 1);
    bus.ack_fsm_cordic = 1'b1;
    @(negedge clk);
    bus.ack_fsm_cordic = 1'b0;
    check("timeout error cleared", bus.error_cordic, 0);
    check("timeout INIT after ack", bus.reset_reg_cordic, 1);

    // Asynchronous reset in the middle of an operation.
    resp_delay = 1;
    @(negedge clk);
    bus.operation = 1'b1; bus.mode_in = 1'b0; bus.shift_region_flag = 2'b01;
    bus.beg_fsm_cordic = 1'b1;
    @(negedge clk);
    bus.beg_fsm_cordic = 1'b0;
    repeat (20) @(negedge clk);
    check("abort busy before reset", bus.busy, 1);
    #2 reset = 1'b1;
    #1;
    check("abort reset_reg_cordic", bus.reset_reg_cordic, 1);
    check("abort other outputs", other_outs(), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("abort back to IDLE", {bus.reset_reg_cordic, bus.busy}, 0);
    run_op(vecs[4], 1'b0, 1'b0, "after_abort");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
